// File: rtl/bsg_cache_nb_dma_scheduler.sv
// rtl/bsg_cache_nb_dma_scheduler.sv - orders cache DMA evicts/refills onto split memory read/write channels
module bsg_cache_nb_dma_scheduler #(
    parameter int dma_pkt_width_p        = 64,
    parameter int dma_data_width_p       = 128,
    parameter int block_size_in_bursts_p = 4,
    parameter int mshr_els_p             = 4,
    parameter int evict_els_p            = 4,
    parameter int max_reads_p            = 4,
    localparam int lg_mshr_els           = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [dma_pkt_width_p-1:0]  cache_dma_pkt_i,
    input  logic                        cache_dma_pkt_v_i,
    output logic                        cache_dma_pkt_yumi_o,

    input  logic [dma_data_width_p-1:0] cache_dma_data_i,
    input  logic                        cache_dma_data_v_i,
    output logic                        cache_dma_data_yumi_o,

    output logic [dma_data_width_p-1:0] cache_refill_data_o,
    output logic [lg_mshr_els-1:0]      cache_refill_mshr_id_o,
    output logic                        cache_refill_v_o,
    input  logic                        cache_refill_ready_i,

    output logic [dma_pkt_width_p-1:0]  mem_read_pkt_o,
    output logic                        mem_read_pkt_v_o,
    input  logic                        mem_read_pkt_yumi_i,

    output logic [dma_pkt_width_p-1:0]  mem_write_pkt_o,
    output logic                        mem_write_pkt_v_o,
    input  logic                        mem_write_pkt_yumi_i,

    output logic [dma_data_width_p-1:0] mem_write_data_o,
    output logic                        mem_write_data_v_o,
    input  logic                        mem_write_data_yumi_i,

    input  logic [dma_data_width_p-1:0] mem_refill_data_i,
    input  logic [lg_mshr_els-1:0]      mem_refill_mshr_id_i,
    input  logic                        mem_refill_v_i,
    output logic                        mem_refill_ready_o,

    output logic                        busy_o
);

    localparam int lg_evict_els = (evict_els_p > 1) ? $clog2(evict_els_p) : 1;
    localparam int evq_cnt_w    = $clog2(evict_els_p + 1);
    localparam int beat_w       = (block_size_in_bursts_p > 1) ? $clog2(block_size_in_bursts_p) : 1;
    localparam int rd_cnt_w     = $clog2(max_reads_p + 1);

    localparam logic [beat_w-1:0]       last_beat_lp = beat_w'(block_size_in_bursts_p - 1);
    localparam logic [lg_evict_els-1:0] last_slot_lp = lg_evict_els'(evict_els_p - 1);
    localparam logic [evq_cnt_w-1:0]    evq_full_lp  = evq_cnt_w'(evict_els_p);
    localparam logic [rd_cnt_w-1:0]     rd_max_lp    = rd_cnt_w'(max_reads_p);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_DATA = 2'd2
    } wstate_e;

    wstate_e                    wstate, wstate_n;
    logic [dma_pkt_width_p-1:0] evq_mem [evict_els_p];
    logic [lg_evict_els-1:0]    evq_wptr, evq_rptr;
    logic [evq_cnt_w-1:0]       evq_cnt;
    logic [beat_w-1:0]          wbeat, wbeat_n;
    logic [beat_w-1:0]          rbeat;
    logic [rd_cnt_w-1:0]        rd_cnt;

    logic wnr, evq_full, evq_empty, evq_push, evq_pop;
    logic rd_fire, rf_fire, rf_last;

    // Packet decode: writes go into the evict queue, reads wait until every older evict has left.
    always_comb begin
        wnr                  = cache_dma_pkt_i[dma_pkt_width_p-1];
        evq_full             = (evq_cnt == evq_full_lp);
        evq_empty            = (evq_cnt == '0);
        evq_push             = reset_i & cache_dma_pkt_v_i & wnr & ~evq_full;
        mem_read_pkt_o       = cache_dma_pkt_i;
        mem_read_pkt_v_o     = reset_i & cache_dma_pkt_v_i & ~wnr & evq_empty
                             & (wstate == W_IDLE) & (rd_cnt < rd_max_lp);
        rd_fire              = mem_read_pkt_v_o & mem_read_pkt_yumi_i;
        cache_dma_pkt_yumi_o = evq_push | rd_fire;
        mem_write_pkt_o      = evq_mem[evq_rptr];
        mem_write_data_o     = cache_dma_data_i;
        busy_o               = ~evq_empty | (wstate != W_IDLE) | (rd_cnt != '0);
    end

    // Refill path is a straight pass-through; the beat counter finds each block's last beat.
    always_comb begin
        cache_refill_data_o    = mem_refill_data_i;
        cache_refill_mshr_id_o = mem_refill_mshr_id_i;
        cache_refill_v_o       = reset_i & mem_refill_v_i;
        mem_refill_ready_o     = cache_refill_ready_i;
        rf_fire                = cache_refill_v_o & cache_refill_ready_i;
        rf_last                = rf_fire & (rbeat == last_beat_lp);
    end

    // Write sequencer: issue the queue head, then stream exactly one block of evict beats behind it.
    always_comb begin
        wstate_n              = wstate;
        wbeat_n               = wbeat;
        evq_pop               = 1'b0;
        mem_write_pkt_v_o     = 1'b0;
        mem_write_data_v_o    = 1'b0;
        cache_dma_data_yumi_o = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (!evq_empty) wstate_n = W_REQ;
            end
            W_REQ: begin
                mem_write_pkt_v_o = 1'b1;
                if (mem_write_pkt_yumi_i) begin
                    wbeat_n  = '0;
                    wstate_n = W_DATA;
                end
            end
            W_DATA: begin
                mem_write_data_v_o    = cache_dma_data_v_i;
                cache_dma_data_yumi_o = cache_dma_data_v_i & mem_write_data_yumi_i;
                if (cache_dma_data_yumi_o) begin
                    if (wbeat == last_beat_lp) begin
                        evq_pop  = 1'b1;
                        wbeat_n  = '0;
                        // Another entry remains if more than one was queued or one arrives now.
                        wstate_n = ((evq_cnt != evq_cnt_w'(1)) | evq_push) ? W_REQ : W_IDLE;
                    end else begin
                        wbeat_n = wbeat + 1'b1;
                    end
                end
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    // Evict queue payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_i) begin
        if (evq_push) evq_mem[evq_wptr] <= cache_dma_pkt_i;
    end

    // Queue pointers, occupancy, write state and refill/read accounting.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            evq_wptr <= '0;
            evq_rptr <= '0;
            evq_cnt  <= '0;
            wstate   <= W_IDLE;
            wbeat    <= '0;
            rbeat    <= '0;
            rd_cnt   <= '0;
        end else begin
            if (evq_push) evq_wptr <= (evq_wptr == last_slot_lp) ? '0 : evq_wptr + 1'b1;
            if (evq_pop)  evq_rptr <= (evq_rptr == last_slot_lp) ? '0 : evq_rptr + 1'b1;
            evq_cnt <= evq_cnt + evq_cnt_w'(evq_push) - evq_cnt_w'(evq_pop);
            wstate  <= wstate_n;
            wbeat   <= wbeat_n;
            if (rf_fire) rbeat <= (rbeat == last_beat_lp) ? '0 : rbeat + 1'b1;
            case ({rd_fire, rf_last})
                2'b10:   rd_cnt <= rd_cnt + 1'b1;
                2'b01:   rd_cnt <= rd_cnt - 1'b1;
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    refill_needs_read: assert property (@(posedge clk_i) disable iff (!reset_i)
        rf_fire |-> (rd_cnt != '0))
        else $error("refill beat accepted with no outstanding read");

endmodule

// File: tb/tb_bsg_cache_nb_dma_scheduler.sv
// tb/tb_bsg_cache_nb_dma_scheduler.sv - scoreboard bench for bsg_cache_nb_dma_scheduler
module tb_bsg_cache_nb_dma_scheduler;

    logic         clk;
    logic         reset_i;
    logic [63:0]  cache_dma_pkt_i;
    logic         cache_dma_pkt_v_i;
    logic         cache_dma_pkt_yumi_o;
    logic [127:0] cache_dma_data_i;
    logic         cache_dma_data_v_i;
    logic         cache_dma_data_yumi_o;
    logic [127:0] cache_refill_data_o;
    logic [1:0]   cache_refill_mshr_id_o;
    logic         cache_refill_v_o;
    logic         cache_refill_ready_i;
    logic [63:0]  mem_read_pkt_o;
    logic         mem_read_pkt_v_o;
    logic         mem_read_pkt_yumi_i;
    logic [63:0]  mem_write_pkt_o;
    logic         mem_write_pkt_v_o;
    logic         mem_write_pkt_yumi_i;
    logic [127:0] mem_write_data_o;
    logic         mem_write_data_v_o;
    logic         mem_write_data_yumi_i;
    logic [127:0] mem_refill_data_i;
    logic [1:0]   mem_refill_mshr_id_i;
    logic         mem_refill_v_i;
    logic         mem_refill_ready_o;
    logic         busy_o;

    bsg_cache_nb_dma_scheduler dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .cache_dma_pkt_i        (cache_dma_pkt_i),
        .cache_dma_pkt_v_i      (cache_dma_pkt_v_i),
        .cache_dma_pkt_yumi_o   (cache_dma_pkt_yumi_o),
        .cache_dma_data_i       (cache_dma_data_i),
        .cache_dma_data_v_i     (cache_dma_data_v_i),
        .cache_dma_data_yumi_o  (cache_dma_data_yumi_o),
        .cache_refill_data_o    (cache_refill_data_o),
        .cache_refill_mshr_id_o (cache_refill_mshr_id_o),
        .cache_refill_v_o       (cache_refill_v_o),
        .cache_refill_ready_i   (cache_refill_ready_i),
        .mem_read_pkt_o         (mem_read_pkt_o),
        .mem_read_pkt_v_o       (mem_read_pkt_v_o),
        .mem_read_pkt_yumi_i    (mem_read_pkt_yumi_i),
        .mem_write_pkt_o        (mem_write_pkt_o),
        .mem_write_pkt_v_o      (mem_write_pkt_v_o),
        .mem_write_pkt_yumi_i   (mem_write_pkt_yumi_i),
        .mem_write_data_o       (mem_write_data_o),
        .mem_write_data_v_o     (mem_write_data_v_o),
        .mem_write_data_yumi_i  (mem_write_data_yumi_i),
        .mem_refill_data_i      (mem_refill_data_i),
        .mem_refill_mshr_id_i   (mem_refill_mshr_id_i),
        .mem_refill_v_i         (mem_refill_v_i),
        .mem_refill_ready_o     (mem_refill_ready_o),
        .busy_o                 (busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;
    int rf_beat = 0;
    logic [31:0] cyc = 0;
    logic [31:0] last_wbeat_cyc = 0, last_wpkt_cyc = 0, last_rd_cyc = 0, last_rf_cyc = 0, last_acc_cyc = 0;
    logic        hold_prev = 1'b0;
    logic [63:0] prev_wpkt = '0;

    logic [63:0]  exp_wpkt[$];
    logic [63:0]  exp_rpkt[$];
    logic [127:0] exp_wdata[$];
    logic [127:0] exp_rf_data[$];
    logic [1:0]   exp_rf_id[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       cache_refill_ready_i = 1'b0;
            1:       cache_refill_ready_i = 1'b1;
            default: cache_refill_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_pkt(input logic wnr);
        return {wnr, 31'($urandom), 32'($urandom)};
    endfunction

    // Output monitor: every handshake pops and compares the matching scoreboard queue.
    always @(negedge clk) begin
        if (reset_i === 1'b1) begin
            if (mem_write_pkt_v_o && hold_prev)
                chk("wpkt_stable", 128'(mem_write_pkt_o), 128'(prev_wpkt));
            if (mem_write_pkt_v_o && mem_write_pkt_yumi_i) begin
                if (exp_wpkt.size() == 0) chk("wpkt_unexpected", 128'(mem_write_pkt_v_o), 128'(0));
                else chk("wpkt", 128'(mem_write_pkt_o), 128'(exp_wpkt.pop_front()));
                last_wpkt_cyc = cyc;
            end
            hold_prev = mem_write_pkt_v_o & ~mem_write_pkt_yumi_i;
            prev_wpkt = mem_write_pkt_o;
            if (mem_write_data_v_o && mem_write_data_yumi_i) begin
                if (exp_wdata.size() == 0) chk("wdata_unexpected", 128'(mem_write_data_v_o), 128'(0));
                else chk("wdata", mem_write_data_o, exp_wdata.pop_front());
                last_wbeat_cyc = cyc;
            end
            if (mem_read_pkt_v_o && mem_read_pkt_yumi_i) begin
                if (exp_rpkt.size() == 0) chk("rpkt_unexpected", 128'(mem_read_pkt_v_o), 128'(0));
                else chk("rpkt", 128'(mem_read_pkt_o), 128'(exp_rpkt.pop_front()));
                chk("rpkt_cache_yumi", 128'(cache_dma_pkt_yumi_o), 128'(1));
                last_rd_cyc = cyc;
            end
            if (cache_refill_v_o && cache_refill_ready_i) begin
                if (exp_rf_data.size() == 0) chk("refill_unexpected", 128'(cache_refill_v_o), 128'(0));
                else begin
                    chk("refill_data", cache_refill_data_o, exp_rf_data.pop_front());
                    chk("refill_id", 128'(cache_refill_mshr_id_o), 128'(exp_rf_id.pop_front()));
                end
                rf_beat++;
                if (rf_beat == 4) begin
                    rf_beat = 0;
                    last_rf_cyc = cyc;
                end
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic send_pkt(input logic [63:0] p);
        int n;
        if (p[63]) exp_wpkt.push_back(p);
        else exp_rpkt.push_back(p);
        cache_dma_pkt_i   = p;
        cache_dma_pkt_v_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cache_dma_pkt_yumi_o && n < 300);
        chk("pkt_yumi", 128'(cache_dma_pkt_yumi_o), 128'(1));
        last_acc_cyc = cyc;
        @(posedge clk); #1;
        cache_dma_pkt_v_i = 1'b0;
    endtask

    task automatic send_beats(input int nb, input logic [127:0] base);
        int n;
        for (int i = 0; i < nb; i++) begin
            cache_dma_data_i   = base + 128'(i);
            cache_dma_data_v_i = 1'b1;
            exp_wdata.push_back(base + 128'(i));
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!cache_dma_data_yumi_o && n < 300);
            chk("wbeat_yumi", 128'(cache_dma_data_yumi_o), 128'(1));
            @(posedge clk); #1;
        end
        cache_dma_data_v_i = 1'b0;
    endtask

    task automatic send_refill(input logic [1:0] id, input logic [127:0] base);
        int n;
        for (int i = 0; i < 4; i++) begin
            mem_refill_data_i    = base + 128'(i);
            mem_refill_mshr_id_i = id;
            mem_refill_v_i       = 1'b1;
            exp_rf_data.push_back(base + 128'(i));
            exp_rf_id.push_back(id);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_refill_ready_o && n < 300);
            chk("refill_ready", 128'(mem_refill_ready_o), 128'(1));
            @(posedge clk); #1;
        end
        mem_refill_v_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [63:0] p;
        reset_i = 1'b0;
        cache_dma_pkt_i       = 64'h0000_0000_0000_1234;
        cache_dma_pkt_v_i     = 1'b1;
        cache_dma_data_i      = '0;
        cache_dma_data_v_i    = 1'b1;
        mem_read_pkt_yumi_i   = 1'b1;
        mem_write_pkt_yumi_i  = 1'b1;
        mem_write_data_yumi_i = 1'b1;
        mem_refill_data_i     = '0;
        mem_refill_mshr_id_i  = '0;
        mem_refill_v_i        = 1'b1;
        ready_mode            = 1;

        // Reset: every valid/yumi held low even with all inputs asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_v", 128'(mem_read_pkt_v_o), 128'(0));
        chk("rst_pkt_yumi", 128'(cache_dma_pkt_yumi_o), 128'(0));
        chk("rst_refill_v", 128'(cache_refill_v_o), 128'(0));
        chk("rst_data_yumi", 128'(cache_dma_data_yumi_o), 128'(0));
        chk("rst_wdata_v", 128'(mem_write_data_v_o), 128'(0));
        chk("rst_wpkt_v", 128'(mem_write_pkt_v_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_ready1", 128'(mem_refill_ready_o), 128'(1));
        ready_mode = 0;
        @(posedge clk); #2;
        chk("rst_ready0", 128'(mem_refill_ready_o), 128'(0));
        cache_dma_pkt_v_i  = 1'b0;
        cache_dma_data_v_i = 1'b0;
        mem_refill_v_i     = 1'b0;
        ready_mode         = 1;
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;

        // Single evict: head visible at t+2, beats only accepted in W_DATA.
        p = mk_pkt(1'b1);
        exp_wpkt.push_back(p);
        cache_dma_pkt_i    = p;
        cache_dma_pkt_v_i  = 1'b1;
        cache_dma_data_i   = 128'hA0;
        cache_dma_data_v_i = 1'b1;
        @(negedge clk);
        chk("ev_acc", 128'(cache_dma_pkt_yumi_o), 128'(1));
        chk("ev_t0_wpv", 128'(mem_write_pkt_v_o), 128'(0));
        chk("ev_t0_dyumi", 128'(cache_dma_data_yumi_o), 128'(0));
        @(posedge clk); #1;
        cache_dma_pkt_v_i = 1'b0;
        @(negedge clk);
        chk("ev_t1_wpv", 128'(mem_write_pkt_v_o), 128'(0));
        chk("ev_t1_busy", 128'(busy_o), 128'(1));
        @(negedge clk);
        chk("ev_t2_wpv", 128'(mem_write_pkt_v_o), 128'(1));
        chk("ev_t2_dyumi", 128'(cache_dma_data_yumi_o), 128'(0));
        @(posedge clk); #1;
        cache_dma_data_v_i = 1'b0;
        send_beats(4, 128'hA0);
        @(negedge clk);
        chk("ev_busy", 128'(busy_o), 128'(0));
        chk("ev_sb", 128'(exp_wpkt.size() + exp_wdata.size()), 128'(0));
        @(posedge clk); #1;

        // Read behind evict: the read waits for the last evict beat, then issues next cycle.
        send_pkt(mk_pkt(1'b1));
        fork
            send_pkt(mk_pkt(1'b0));
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("rbe_hold", 128'(mem_read_pkt_v_o), 128'(0));
                end
                @(posedge clk); #1;
                send_beats(4, 128'h50);
            end
        join
        chk("rbe_order", 128'(last_rd_cyc), 128'(last_wbeat_cyc + 1));
        send_refill(2'd0, 128'h600);
        @(negedge clk);
        chk("rbe_busy", 128'(busy_o), 128'(0));
        @(posedge clk); #1;

        // Queue full: four accepted, the fifth waits until the first block has fully drained.
        mem_write_pkt_yumi_i = 1'b0;
        for (int i = 0; i < 4; i++) send_pkt(mk_pkt(1'b1));
        p = mk_pkt(1'b1);
        cache_dma_pkt_i   = p;
        cache_dma_pkt_v_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("qf_stall", 128'(cache_dma_pkt_yumi_o), 128'(0));
        end
        @(posedge clk); #1;
        mem_write_pkt_yumi_i = 1'b1;
        fork
            send_pkt(p);
            send_beats(4, 128'hC0);
        join
        chk("qf_release", 128'(last_acc_cyc), 128'(last_wbeat_cyc + 1));
        chk("qf_b2b", 128'(last_wpkt_cyc), 128'(last_wbeat_cyc + 1));
        send_beats(16, 128'hD0);
        @(negedge clk);
        chk("qf_busy", 128'(busy_o), 128'(0));
        @(posedge clk); #1;

        // Read limit: four outstanding, the fifth released the cycle after a block's last beat.
        for (int i = 0; i < 4; i++) send_pkt(mk_pkt(1'b0));
        p = mk_pkt(1'b0);
        cache_dma_pkt_i   = p;
        cache_dma_pkt_v_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rl_stall", 128'(mem_read_pkt_v_o), 128'(0));
        end
        @(posedge clk); #1;
        fork
            send_pkt(p);
            send_refill(2'd1, 128'h100);
        join
        chk("rl_release", 128'(last_rd_cyc), 128'(last_rf_cyc + 1));
        send_refill(2'd2, 128'h200);

        // Read issue coinciding with a last refill beat leaves the count unchanged (3).
        mem_read_pkt_yumi_i = 1'b0;
        p = mk_pkt(1'b0);
        exp_rpkt.push_back(p);
        cache_dma_pkt_i   = p;
        cache_dma_pkt_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_refill_data_i    = 128'h300 + 128'(i);
            mem_refill_mshr_id_i = 2'd3;
            mem_refill_v_i       = 1'b1;
            exp_rf_data.push_back(128'h300 + 128'(i));
            exp_rf_id.push_back(2'd3);
            mem_read_pkt_yumi_i = (i == 3);
            @(negedge clk);
            if (i == 3) chk("sim_rd_v", 128'(mem_read_pkt_v_o), 128'(1));
            @(posedge clk); #1;
        end
        mem_refill_v_i      = 1'b0;
        cache_dma_pkt_v_i   = 1'b0;
        mem_read_pkt_yumi_i = 1'b1;
        chk("sim_same_cycle", 128'(last_rd_cyc), 128'(last_rf_cyc));
        send_pkt(mk_pkt(1'b0));
        cache_dma_pkt_i   = mk_pkt(1'b0);
        cache_dma_pkt_v_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rd_full_stall", 128'(mem_read_pkt_v_o), 128'(0));
        end
        @(posedge clk); #1;
        cache_dma_pkt_v_i = 1'b0;

        // Refill backpressure: random ready, count drops only on the fourth accepted beat.
        ready_mode = 2;
        fork
            begin
                send_pkt(mk_pkt(1'b0));
                chk("bp_release", 128'(last_rd_cyc), 128'(last_rf_cyc + 1));
            end
            begin
                for (int b = 0; b < 5; b++) begin
                    if (b == 4) chk("bp_busy_before", 128'(busy_o), 128'(1));
                    send_refill(2'(b), 128'h400 + 128'(b * 16));
                end
            end
        join
        ready_mode = 1;
        @(negedge clk);
        chk("bp_busy", 128'(busy_o), 128'(0));
        @(posedge clk); #1;

        // Reset mid-block: valids drop at once, a fresh evict then completes.
        send_pkt(mk_pkt(1'b1));
        send_beats(2, 128'hB0);
        mem_write_data_yumi_i = 1'b0;
        cache_dma_data_i      = 128'hB2;
        cache_dma_data_v_i    = 1'b1;
        @(negedge clk);
        chk("mid_pre_v", 128'(mem_write_data_v_o), 128'(1));
        #1;
        mem_write_data_yumi_i = 1'b1;
        reset_i = 1'b0;
        #1;
        chk("mid_wdata_v", 128'(mem_write_data_v_o), 128'(0));
        chk("mid_data_yumi", 128'(cache_dma_data_yumi_o), 128'(0));
        chk("mid_wpkt_v", 128'(mem_write_pkt_v_o), 128'(0));
        chk("mid_busy", 128'(busy_o), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        cache_dma_data_v_i = 1'b0;
        reset_i = 1'b1;
        @(posedge clk); #1;
        send_pkt(mk_pkt(1'b1));
        send_beats(4, 128'hE0);
        @(negedge clk);
        chk("post_rst_busy", 128'(busy_o), 128'(0));
        chk("sb_drained", 128'(exp_wpkt.size() + exp_wdata.size() + exp_rpkt.size() + exp_rf_data.size()),
            128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
